// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the condition/flag unit: ARM condition codes and
// bit positions of the {N,Z,C,V} status nibble.
package cond_flag_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Signal bundle between ID/WB (master side) and the condition/flag unit (slave side).
interface cond_flag_unit_if #(
  parameter int LANES       = 1,
  parameter int MAX_PENDING = 3
);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic                flush;
  logic [LANES-1:0]    id_valid;
  logic [4*LANES-1:0]  id_cond;
  logic [LANES-1:0]    id_sets_flags;
  logic                wb_flag_we;
  logic [3:0]          wb_flags;
  logic                id_stall;
  logic [LANES-1:0]    ex_valid;
  logic [LANES-1:0]    ex_exec;
  logic [3:0]          status_q;
  logic [PEND_W-1:0]   pending_cnt;

  modport master (
    output flush, id_valid, id_cond, id_sets_flags, wb_flag_we, wb_flags,
    input  id_stall, ex_valid, ex_exec, status_q, pending_cnt
  );

  modport slave (
    input  flush, id_valid, id_cond, id_sets_flags, wb_flag_we, wb_flags,
    output id_stall, ex_valid, ex_exec, status_q, pending_cnt
  );

endinterface

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational ARM condition check: 4-bit condition field against {N,Z,C,V}.
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV status register, in-flight flag-writer tracking and ID stall generation
// for up to LANES instructions per cycle, with a registered per-lane execute flag.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int LANES       = 1,
  parameter int MAX_PENDING = 3
) (
  input  logic             clk,
  input  logic             rst,
  cond_flag_unit_if.slave  bus
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int SET_W  = $clog2(LANES + 1);
  localparam int SUM_W  = PEND_W + SET_W + 1;

  logic [3:0]        status_q, status_d;
  logic [PEND_W-1:0] pending_cnt_q, pending_cnt_d;
  logic [LANES-1:0]  ex_valid_q, ex_valid_d;
  logic [LANES-1:0]  ex_exec_q, ex_exec_d;

  logic [3:0]        eff_flags;
  logic [PEND_W-1:0] pend_eff;
  logic [LANES-1:0]  lane_pass;
  logic [LANES-1:0]  accepted;
  logic [SET_W-1:0]  n_set;
  logic [SUM_W-1:0]  demand;
  logic              hazard, setter_ahead, stall, issue;

  // WB bypass: an instruction issuing alongside a flag commit sees the new flags.
  assign eff_flags = bus.wb_flag_we ? bus.wb_flags : status_q;
  assign pend_eff  = pending_cnt_q - PEND_W'(bus.wb_flag_we && (pending_cnt_q != '0));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cond_eval u_cond_eval (
      .cond  (bus.id_cond[4*g +: 4]),
      .flags (eff_flags),
      .pass  (lane_pass[g])
    );
  end

  // A conditional lane is stale if any older writer is still in flight,
  // including an older lane of the same group.
  always_comb begin
    hazard       = 1'b0;
    setter_ahead = 1'b0;
    n_set        = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.id_valid[i]) begin
        if ((bus.id_cond[4*i +: 4] != COND_AL) && ((pend_eff != '0) || setter_ahead))
          hazard = 1'b1;
        if (bus.id_sets_flags[i]) begin
          setter_ahead = 1'b1;
          n_set        = n_set + SET_W'(1);
        end
      end
    end
    demand = SUM_W'(pend_eff) + SUM_W'(n_set);
    stall  = hazard || (demand > SUM_W'(MAX_PENDING));
  end

  always_comb begin
    issue         = ~stall & ~bus.flush;
    accepted      = bus.id_valid & {LANES{issue}};
    ex_valid_d    = accepted;
    ex_exec_d     = accepted & lane_pass;
    status_d      = bus.wb_flag_we ? bus.wb_flags : status_q;
    pending_cnt_d = pend_eff;
    if (bus.flush)
      pending_cnt_d = '0;
    else if (issue)
      pending_cnt_d = PEND_W'(demand);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q      <= '0;
      pending_cnt_q <= '0;
      ex_valid_q    <= '0;
      ex_exec_q     <= '0;
    end else begin
      status_q      <= status_d;
      pending_cnt_q <= pending_cnt_d;
      ex_valid_q    <= ex_valid_d;
      ex_exec_q     <= ex_exec_d;
    end
  end

  assign bus.id_stall    = stall;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_exec     = ex_exec_q;
  assign bus.status_q    = status_q;
  assign bus.pending_cnt = pending_cnt_q;

  // A WB commit with nothing in flight means the tracking has lost sync with the pipe.
  wb_underflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(bus.wb_flag_we && (pending_cnt_q == '0)));

endmodule
